// File: rtl/hash_pkg.sv
// hash_pkg: shared state encoding, LFSR constants and rotate helper for hash_stream
package hash_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] DEF_SEED  = 32'h1D872B41;
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return ((v << 1) | (v >> (w - 1))) & m;
  endfunction
endpackage

// File: rtl/hash_row_lfsr.sv
// hash_row_lfsr: seeded 32-bit Galois LFSR that supplies one matrix row per enabled step
// Ports: clk, rst (async, active-low), en (advance), row (low HASH_W bits of the next state)
module hash_row_lfsr import hash_pkg::*; #(
  parameter int          HASH_W = 10,
  parameter logic [31:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [HASH_W-1:0] row
);
  localparam logic [31:0] INIT_V = (SEED == 32'd0) ? 32'd1 : SEED;
  logic [31:0] lfsr, nxt;
  assign nxt = lfsr[0] ? (lfsr >> 1) ^ LFSR_POLY : lfsr >> 1;
  assign row = nxt[HASH_W-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= INIT_V;
    else if (en) lfsr <= nxt;
endmodule

// File: rtl/hash_stream.sv
// hash_stream: streaming H3 XOR-matrix hash folding multi-beat keys into a bucket index
// Ports: clk, rst (async, active-low); in_valid/in_ready/in_data/in_last beat input;
//        out_valid/out_ready/out_hash/out_beats result output.
// Optional HASH_CFG_EN adds cfg_we/cfg_addr/cfg_row for run-time matrix row writes.
module hash_stream import hash_pkg::*; #(
  parameter int          DATA_W = 64,
  parameter int          HASH_W = 10,
  parameter int          CNT_W  = 8,
  parameter logic [31:0] SEED   = DEF_SEED,
  localparam int         AW     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HASH_W-1:0] out_hash,
  output logic [CNT_W-1:0]  out_beats
`ifdef HASH_CFG_EN
  ,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [HASH_W-1:0] cfg_row
`endif
);
  state_t            state;
  logic [AW-1:0]     init_cnt;
  logic [HASH_W-1:0] rows [DATA_W];
  logic [HASH_W-1:0] acc, beat_h, acc_next, lfsr_row;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              xfer;
  hash_row_lfsr #(.HASH_W(HASH_W), .SEED(SEED)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (state == INIT),
    .row(lfsr_row)
  );
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign cnt_inc  = &cnt ? cnt : cnt + 1'b1;
  assign acc_next = HASH_W'(rotl1(32'(acc), HASH_W)) ^ beat_h;
  always_comb begin
    beat_h = '0;
    for (int i = 0; i < DATA_W; i++) beat_h ^= in_data[i] ? rows[i] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_beats <= '0;
      for (int i = 0; i < DATA_W; i++) rows[i] <= '0;
    end else if (state == INIT) begin
      rows[init_cnt] <= lfsr_row;
      init_cnt       <= init_cnt + 1'b1;
      if (init_cnt == AW'(DATA_W - 1)) state <= RUN;
    end else begin
      if (xfer && in_last) begin
        out_hash  <= acc_next;
        out_beats <= cnt_inc;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (xfer) begin
          acc <= acc_next;
          cnt <= cnt_inc;
        end
      end
`ifdef HASH_CFG_EN
      if (cfg_we && 32'(cfg_addr) < DATA_W) rows[cfg_addr] <= cfg_row;
`endif
    end
  end
endmodule
